// File: rtl/coeff_loader_pkg.sv
// coeff_loader_pkg: shared FSM state type and sizing helpers for the coefficient loader
package coeff_loader_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/coeff_loader_param_edge.sv
// rise_edge_detect: flags a 0->1 transition of d using a registered copy of the previous value
module rise_edge_detect (
    input  logic clk,
    input  logic n_rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    // remember last cycle's value so a rise is a one-cycle event
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) d_q <= 1'b0;
        else        d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/coeff_loader_param.sv
// coeff_loader_param: sequences NUM_COEFF coefficients into the FIR controller, paced by modwait
module coeff_loader_param
    import coeff_loader_pkg::*;
#(
    parameter int NUM_COEFF = 4,
    parameter int COEFF_W   = 16,
    parameter int IDX_W     = idx_width(NUM_COEFF)
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         new_coefficient_set,
    input  logic [NUM_COEFF*COEFF_W-1:0] coeff_in,
    input  logic                         modwait,
    output logic                         load_coeff,
    output logic [IDX_W-1:0]             coefficient_num,
    output logic [COEFF_W-1:0]           coeff_out,
    output logic                         clear_new_coeff,
    output logic                         load_done,
    output logic                         busy
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_COEFF - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             pend, pend_nxt;
    logic             rise;

    rise_edge_detect u_edge (
        .clk  (clk),
        .n_rst(n_rst),
        .d    (new_coefficient_set),
        .rise (rise)
    );

    // state, index and pending-restart registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            idx   <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            pend  <= pend_nxt;
        end
    end

    // next-state, index sequencing, restart capture and handshake pulses
    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        pend_nxt        = pend | (rise && (state == LOAD || state == WAIT));
        load_coeff      = 1'b0;
        load_done       = 1'b0;
        clear_new_coeff = 1'b0;
        case (state)
            IDLE: begin
                if (new_coefficient_set && !modwait) begin
                    state_nxt = LOAD;
                    idx_nxt   = '0;
                end
            end
            LOAD: begin
                load_coeff = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (!modwait) begin
                    if (pend) begin
                        state_nxt = LOAD;
                        idx_nxt   = '0;
                        pend_nxt  = 1'b0;
                    end else if (idx == LAST) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = LOAD;
                        idx_nxt   = idx + 1'b1;
                    end
                end
            end
            DONE: begin
                idx_nxt  = '0;
                pend_nxt = 1'b0;
                if (rise || pend) begin
                    state_nxt = LOAD;
                end else begin
                    state_nxt       = IDLE;
                    load_done       = 1'b1;
                    clear_new_coeff = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
                pend_nxt  = 1'b0;
            end
        endcase
    end

    assign busy            = (state != IDLE);
    assign coefficient_num = idx;
    assign coeff_out       = coeff_in[idx*COEFF_W +: COEFF_W];

endmodule

// File: tb/tb_coeff_loader_param.sv
// tb_coeff_loader_param: table, hand-written and randomized checks of the coefficient loader
module tb_coeff_loader_param;

    typedef struct {
        logic [63:0] c;
        int          h0, h1, h2, h3;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic n_rst = 1'b1;

    logic         flag = 1'b0, mw = 1'b0;
    logic [63:0]  cin = '0;
    logic         ld, cc, dn, bz;
    logic [1:0]   cn;
    logic [15:0]  co;

    logic         flag1 = 1'b0, mw1 = 1'b0;
    logic [15:0]  cin1 = '0;
    logic         ld1, cc1, dn1, bz1;
    logic [0:0]   cn1;
    logic [15:0]  co1;

    logic         flag8 = 1'b0, mw8 = 1'b0;
    logic [127:0] cin8 = '0;
    logic         ld8, cc8, dn8, bz8;
    logic [2:0]   cn8;
    logic [15:0]  co8;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int exp_idx = 0, last_idx = 0, loads = 0, dones = 0, clears = 0, done_at = 0, rem = 0;
    int hold [4] = '{1, 1, 1, 1};
    int rs_at = -1;
    bit in_seq = 0, ctl_en = 1, mutate = 0;
    int exp1 = 0, loads1 = 0, dones1 = 0, done1_at = 0, rem1 = 0;
    int exp8 = 0, loads8 = 0, dones8 = 0, done8_at = 0, rem8 = 0;

    always #5 clk = ~clk;

    coeff_loader_param #(.NUM_COEFF(4), .COEFF_W(16)) u4 (
        .clk(clk), .n_rst(n_rst), .new_coefficient_set(flag), .coeff_in(cin), .modwait(mw),
        .load_coeff(ld), .coefficient_num(cn), .coeff_out(co), .clear_new_coeff(cc),
        .load_done(dn), .busy(bz)
    );

    coeff_loader_param #(.NUM_COEFF(1), .COEFF_W(16)) u1 (
        .clk(clk), .n_rst(n_rst), .new_coefficient_set(flag1), .coeff_in(cin1), .modwait(mw1),
        .load_coeff(ld1), .coefficient_num(cn1), .coeff_out(co1), .clear_new_coeff(cc1),
        .load_done(dn1), .busy(bz1)
    );

    coeff_loader_param #(.NUM_COEFF(8), .COEFF_W(16)) u8 (
        .clk(clk), .n_rst(n_rst), .new_coefficient_set(flag8), .coeff_in(cin8), .modwait(mw8),
        .load_coeff(ld8), .coefficient_num(cn8), .coeff_out(co8), .clear_new_coeff(cc8),
        .load_done(dn8), .busy(bz8)
    );

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // one clock: sample all DUTs, score them and play the FIR controller / register file
    task automatic step();
        logic [127:0] t;
        @(posedge clk);
        #1;
        cyc++;
        if (ld) begin
            check("load_while_modwait", mw, 1'b0);
            check("load_index", cn, exp_idx);
            t = cin >> (16 * exp_idx);
            check("load_data", co, t[15:0]);
            last_idx = exp_idx;
            exp_idx++;
            loads++;
            in_seq = 1;
            if (ctl_en) begin
                rem = hold[last_idx & 3];
                mw  = (rem > 0);
            end
        end else begin
            if (in_seq) check("index_hold", cn, last_idx);
            if (ctl_en) begin
                if (rem > 0) rem--;
                else mw = 1'b0;
            end
        end
        check("busy", bz, in_seq);
        if (cc) begin
            clears++;
            flag = 1'b0;
        end
        if (dn) begin
            check("done_after_full_set", exp_idx, 4);
            dones++;
            done_at = cyc;
            in_seq = 0;
            exp_idx = 0;
        end
        if (ld1) begin
            check("n1_index", cn1, exp1);
            check("n1_data", co1, cin1);
            exp1++;
            loads1++;
            mw1 = 1'b1;
            rem1 = 1;
        end else if (rem1 > 0) rem1--;
        else mw1 = 1'b0;
        if (cc1) flag1 = 1'b0;
        if (dn1) begin
            check("n1_done_after_full_set", exp1, 1);
            dones1++;
            done1_at = cyc;
            exp1 = 0;
        end
        if (ld8) begin
            check("n8_index", cn8, exp8);
            t = cin8 >> (16 * exp8);
            check("n8_data", co8, t[15:0]);
            exp8++;
            loads8++;
            mw8 = 1'b1;
            rem8 = 1;
        end else if (rem8 > 0) rem8--;
        else mw8 = 1'b0;
        if (cc8) flag8 = 1'b0;
        if (dn8) begin
            check("n8_done_after_full_set", exp8, 8);
            dones8++;
            done8_at = cyc;
            exp8 = 0;
        end
    endtask

    // raise the set flag from IDLE and run one complete load to its done pulse
    task automatic run_seq(input string nm, input int lat, input int nloads);
        int s, d0, l0, c0;
        s = cyc; d0 = dones; l0 = loads; c0 = clears;
        flag = 1'b1;
        for (int i = 0; i < 400 && dones == d0; i++) begin
            step();
            if (rs_at >= 0 && ld && last_idx == rs_at) begin
                rs_at = -1;
                step();
                flag = 1'b0;
                step();
                flag = 1'b1;
                exp_idx = 0;
            end
            if (mutate && $urandom_range(0, 7) == 0) cin = {$urandom, $urandom};
        end
        check({nm, "_done_pulses"}, dones - d0, 1);
        check({nm, "_clear_pulses"}, clears - c0, 1);
        check({nm, "_loads"}, loads - l0, nloads);
        if (lat > 0) check({nm, "_latency"}, done_at - s, lat);
        step();
    endtask

    initial begin
        vec_t vt [5];
        int s, d0;
        vt[0] = '{64'h0004_0003_0002_0001, 1, 1, 1, 1, 13};
        vt[1] = '{64'hdead_beef_1234_a5a5, 0, 0, 0, 0, 9};
        vt[2] = '{64'hffff_0000_8000_0001, 2, 2, 2, 2, 17};
        vt[3] = '{64'h1111_2222_3333_4444, 1, 10, 1, 1, 22};
        vt[4] = '{64'h0f0f_f0f0_55aa_aa55, 4, 0, 3, 1, 17};

        #2 n_rst = 1'b0;
        #1 check("reset_outputs", {ld, cn, cc, dn, bz, ld1, cn1, dn1, bz1, ld8, cn8, dn8, bz8}, '0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            cin = vt[i].c;
            hold = '{vt[i].h0, vt[i].h1, vt[i].h2, vt[i].h3};
            run_seq($sformatf("vec%0d", i), vt[i].lat, 4);
        end

        hold = '{1, 1, 1, 1};
        ctl_en = 0;
        mw = 1'b1;
        flag = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("blocked_no_load", ld, 1'b0);
        end
        mw = 1'b0;
        ctl_en = 1;
        s = cyc;
        d0 = dones;
        step();
        check("blocked_first_load", ld, 1'b1);
        for (int i = 0; i < 100 && dones == d0; i++) step();
        check("blocked_latency", done_at - s, 13);
        step();

        hold = '{1, 1, 3, 1};
        rs_at = 2;
        run_seq("restart", 26, 7);

        hold = '{1, 3, 1, 1};
        d0 = dones;
        flag = 1'b1;
        for (int i = 0; i < 50 && !(ld && last_idx == 1); i++) step();
        step();
        #1 n_rst = 1'b0;
        #1 check("reset_mid_outputs", {ld, cn, cc, dn, bz}, '0);
        exp_idx = 0; in_seq = 0; mw = 1'b0; rem = 0;
        #1 n_rst = 1'b1;
        check("reset_no_done", dones - d0, 0);
        run_seq("after_reset", 15, 4);

        mutate = 1;
        for (int k = 0; k < 25; k++) begin
            int r;
            cin = {$urandom, $urandom};
            for (int j = 0; j < 4; j++) hold[j] = $urandom_range(0, 4);
            r = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
            if (r >= 0 && hold[r] < 2) hold[r] = 2;
            rs_at = r;
            run_seq($sformatf("rand%0d", k), 0, (r >= 0) ? 4 + r + 1 : 4);
        end
        mutate = 0;

        cin1 = 16'(($urandom));
        cin8 = {$urandom, $urandom, $urandom, $urandom};
        s = cyc;
        flag1 = 1'b1;
        flag8 = 1'b1;
        for (int i = 0; i < 200 && (dones1 == 0 || dones8 == 0); i++) step();
        check("n1_loads", loads1, 1);
        check("n8_loads", loads8, 8);
        check("n1_done_pulses", dones1, 1);
        check("n8_done_pulses", dones8, 1);
        check("n1_latency", done1_at - s, 4);
        check("n8_latency", done8_at - s, 25);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1);
    end

endmodule

// File: doc/coeff_loader_param.md
Name: coeff_loader_param

Overview:
Parametrised coefficient loader that sequences NUM_COEFF filter coefficients from the slave register file into the FIR datapath controller. It issues one load_coeff pulse per coefficient and paces loads on modwait. It supports restarting when a new coefficient set arrives mid-sequence, and emits completion and clear handshakes back to the register file. It sits between the AHB slave register block and the FIR controller.

Parameters:
NUM_COEFF, 4, number of coefficients to load (>= 1)
COEFF_W, 16, width of one coefficient
IDX_W, (NUM_COEFF>1 ? $clog2(NUM_COEFF) : 1), width of coefficient index

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
new_coefficient_set  input  1  level flag from register file: coefficient set written, awaiting load
coeff_in  input  NUM_COEFF*COEFF_W  packed coefficients; coefficient k at bits [k*COEFF_W +: COEFF_W]
modwait  input  1  FIR controller busy; no new load while high
load_coeff  output  1  one-cycle strobe: coeff_out/coefficient_num valid, controller must latch
coefficient_num  output  IDX_W  index of coefficient being loaded
coeff_out  output  COEFF_W  coeff_in slice selected by coefficient_num (combinational mux)
clear_new_coeff  output  1  one-cycle pulse: register file clears new_coefficient_set
load_done  output  1  one-cycle pulse: full set loaded
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, n_rst=0): state=IDLE, idx=0, restart_pending=0, edge register=0. Outputs: load_coeff=0, clear_new_coeff=0, load_done=0, busy=0, coefficient_num=0.
- Reset mid-sequence aborts immediately. No load_done, no clear pulse.
- State machine: IDLE, LOAD, WAIT, DONE. Registered state; Moore outputs; coefficient_num = idx register.
- IDLE: if new_coefficient_set=1 and modwait=0, go to LOAD with idx=0. Otherwise stay. A set arriving while modwait=1 waits for modwait=0.
- LOAD (exactly 1 cycle): load_coeff=1, coefficient_num=idx, coeff_out=coeff_in[idx]. Always go to WAIT.
- WAIT: load_coeff=0, coefficient_num holds idx. The FIR controller raises modwait on the edge after LOAD.
  - modwait=1: stay in WAIT.
  - modwait=0 and restart_pending=1: go to LOAD, idx=0, clear restart_pending.
  - modwait=0 and idx==NUM_COEFF-1: go to DONE.
  - modwait=0 otherwise: idx=idx+1, go to LOAD.
- DONE (1 cycle): load_done=1, clear_new_coeff=1. Next state IDLE, idx=0.
  - Exception: a rising edge of new_coefficient_set detected in this same cycle suppresses both pulses and goes to LOAD with idx=0.
- Restart detection: a registered rising-edge detector runs on new_coefficient_set. A rising edge while in LOAD or WAIT sets restart_pending. Further edges while pending is set have no additional effect.
- Latency: set seen in IDLE (modwait=0) -> load_coeff high on the next cycle. With modwait deasserting 1 cycle after rising, the full set takes NUM_COEFF*3+1 cycles from start to load_done.
- NUM_COEFF=1: LOAD -> WAIT -> DONE; idx never increments.
- idx never wraps past NUM_COEFF-1. Illegal state encodings go to IDLE.
- Mid-load changes to coeff_in are not captured. The value sampled is whatever is present during each LOAD cycle.

Decomposition:
- Package coeff_loader_pkg: state_t enum (IDLE, LOAD, WAIT, DONE), localparam state width, helper function for IDX_W.
- One sub-module: rise_edge_detect (clk, n_rst, d, rise). Registered previous value, async active-low reset to 0.
- Top block holds the FSM, the idx counter, restart_pending and the coeff mux.

Test Plan:
- Basic load, NUM_COEFF=4, coeff_in={16'h0004,16'h0003,16'h0002,16'h0001}, modwait high 1 cycle after each load -> four load_coeff pulses with coefficient_num 0,1,2,3 and coeff_out 0001,0002,0003,0004; load_done and clear_new_coeff pulse once, 13 cycles after start.
- Long modwait: modwait held high 10 cycles after the second load -> coefficient_num stays 1, no load_coeff during the hold, sequence resumes with index 2 the cycle after modwait falls.
- Start blocked: new_coefficient_set=1 while modwait=1 for 5 cycles -> busy=0 and no load_coeff until modwait=0; first load the following cycle.
- Restart: new_coefficient_set toggled 0->1 during WAIT of index 2 -> next load is index 0; no load_done until indices 0..3 complete again; exactly one load_done.
- Reset mid-load: assert n_rst=0 during WAIT index 1 -> all outputs 0 asynchronously; after release with new_coefficient_set=1, sequence restarts at index 0.
- NUM_COEFF=1 and NUM_COEFF=8 builds -> 1 and 8 load pulses respectively; index width 1 and 3; load_done after the final index.
